mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning clock cycles each select value is held before y_in is sampled; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  scan request, level-sampled in IDLE (and in DONE when SCAN_CONTINUOUS_EN is defined).
REQ-005 SHALL have port y_in  input  1  output of the downstream 8x1 mux.
REQ-006 SHALL have port sel_out  output  3  channel select driven to the 8x1 mux.
REQ-007 SHALL have port en_out  output  1  mux enable, high only in SCAN.
REQ-008 SHALL have port data_out  output  8  captured scan word; bit k holds the value of channel k.
REQ-009 SHALL have port busy  output  1  high in SCAN.
REQ-010 SHALL have port done  output  1  one-cycle pulse in DONE.

Function
REQ-011 SHALL implement FSM states IDLE, SCAN, DONE, with all outputs registered.
REQ-012 IDLE: when start=1 at a clock edge, go to SCAN with sel_out=0 and settle counter=0; otherwise remain in IDLE.
REQ-013 SCAN: the settle counter SHALL increment each cycle; when it equals SETTLE-1, the block samples y_in into shadow bit [sel_out] and resets the counter.
REQ-014 SCAN, on sampling with sel_out<7: sel_out SHALL increment by 1 on the same edge.
REQ-015 SCAN, on sampling with sel_out=7: go to DONE; sel_out SHALL wrap to 0.
REQ-016 On entry to DONE, data_out SHALL load the complete shadow word, including the bit sampled on that edge; done=1 for exactly that one cycle.
REQ-017 DONE SHALL go to IDLE, except as stated in REQ-024.
REQ-018 Scan latency SHALL be 8*SETTLE cycles in SCAN plus 1 cycle in DONE, counted from the start-accept edge.
REQ-019 In SCAN, start SHALL be ignored; a scan, once accepted, is never restarted or aborted except by rst.
REQ-020 data_out SHALL hold its last value in IDLE and during a new scan; it changes only on entry to DONE.
REQ-021 en_out and busy SHALL be identical, and high for exactly 8*SETTLE cycles per scan.

Reset
REQ-022 On rst=1, immediately and independent of clk: state=IDLE, sel_out=0, en_out=0, busy=0, done=0, data_out=8'h00, shadow=8'h00, settle counter=0.
REQ-023 If rst asserts mid-SCAN, the partial scan SHALL be discarded; after release, only a new start begins a scan.

Configuration
REQ-024 With macro SCAN_CONTINUOUS_EN defined, DONE SHALL go directly to SCAN (sel_out=0, counter=0) when start=1 in DONE, and to IDLE otherwise, giving back-to-back scans with a one-cycle DONE gap.
REQ-025 Without SCAN_CONTINUOUS_EN, DONE SHALL always go to IDLE, and start in DONE SHALL be ignored; a new scan requires start=1 while in IDLE.

Verification
REQ-026 SETTLE=1; start pulsed 1 cycle; y_in modeled as bit [sel_out] of 8'hA6 -> sel_out steps 0..7 on consecutive cycles, busy high 8 cycles, done pulses at cycle 9, data_out=8'hA6.
REQ-027 SETTLE=3; channel pattern 8'h5C -> each sel_out value held 3 cycles, busy high 24 cycles, done at cycle 25, data_out=8'h5C.
REQ-028 SETTLE=1; second start held high throughout the first scan -> no restart; without SCAN_CONTINUOUS_EN, one IDLE cycle follows DONE before the second scan begins.
REQ-029 rst asserted when sel_out=4 during a scan of 8'hFF, with previous data_out=8'h12 -> outputs go to reset values asynchronously and data_out=8'h00; with start=0 after release, the block stays in IDLE.
REQ-030 SCAN_CONTINUOUS_EN defined, start held high, pattern 8'h3C then 8'hC3 -> done pulses every 9 cycles, data_out goes 8'h3C then 8'hC3, busy low only in the DONE cycles.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Scans the eight inputs of a downstream 8x1 mux into one parallel word.
// Optional macro SCAN_CONTINUOUS_EN lets start in DONE launch the next scan directly.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_in,
    output logic [2:0] sel_out,
    output logic       en_out,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state, state_nx;
    logic [2:0] sel_nx;
    logic [3:0] cnt, cnt_nx;
    logic [7:0] shadow, shadow_nx;
    logic [7:0] data_nx;

    always_comb begin
        state_nx  = state;
        sel_nx    = sel_out;
        cnt_nx    = cnt;
        shadow_nx = shadow;
        data_nx   = data_out;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SCAN;
                    sel_nx   = 3'd0;
                    cnt_nx   = 4'd0;
                end
            end
            SCAN: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_nx             = 4'd0;
                    shadow_nx[sel_out] = y_in;
                    if (sel_out == 3'd7) begin
                        // last channel: publish the word including the bit taken on this edge
                        state_nx = DONE;
                        sel_nx   = 3'd0;
                        data_nx  = shadow_nx;
                    end else begin
                        sel_nx = sel_out + 3'd1;
                    end
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                sel_nx   = 3'd0;
                cnt_nx   = 4'd0;
`ifdef SCAN_CONTINUOUS_EN
                if (start) begin
                    state_nx = SCAN;
                end
`else
                state_nx = IDLE;
`endif
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Status outputs are derived from the next state so they are registered yet aligned with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel_out  <= 3'd0;
            cnt      <= 4'd0;
            shadow   <= 8'h00;
            data_out <= 8'h00;
            en_out   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            sel_out  <= sel_nx;
            cnt      <= cnt_nx;
            shadow   <= shadow_nx;
            data_out <= data_nx;
            en_out   <= (state_nx == SCAN);
            busy     <= (state_nx == SCAN);
            done     <= (state_nx == DONE);
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: one instance with SETTLE=1 and one with SETTLE=3,
// each feeding y_in from a stored channel pattern indexed by the select lines.
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst1, rst3;
    logic       start1, start3;
    logic [7:0] pat1, pat3;
    logic       y1, y3;
    logic [2:0] sel1, sel3;
    logic       en1, en3, busy1, busy3, done1, done3;
    logic [7:0] data1, data3;

    int total = 0;
    int bad   = 0;

    logic [7:0] q1[$];
    logic [7:0] q3[$];

    assign y1 = pat1[sel1];
    assign y3 = pat3[sel3];

    mux_scan_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .y_in(y1), .sel_out(sel1),
        .en_out(en1), .data_out(data1), .busy(busy1), .done(done1)
    );

    mux_scan_ctrl #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst3), .start(start3), .y_in(y3), .sel_out(sel3),
        .en_out(en3), .data_out(data3), .busy(busy3), .done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: expected event did not occur", name);
    endtask

    task automatic waitDone(input int which, output int cyc);
        cyc = 0;
        while (!((which == 1) ? done1 : done3) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) failNow((which == 1) ? "timeout1" : "timeout3");
    endtask

    // Launch one scan from IDLE and check its latency from the accept edge.
    task automatic applyStimulus(input int which, input logic [7:0] p);
        int cyc;
        int s;
        s = (which == 1) ? 1 : 3;
        @(negedge clk);
        if (which == 1) begin
            pat1 = p;
            q1.push_back(p);
            start1 = 1'b1;
        end else begin
            pat3 = p;
            q3.push_back(p);
            start3 = 1'b1;
        end
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
        waitDone(which, cyc);
        checkOutput((which == 1) ? "latency1" : "latency3", cyc + 1, 8 * s + 1);
    endtask

    // Monitor for the SETTLE=1 instance.
    int         bcnt1 = 0;
    logic [7:0] last1 = 8'h00;
    logic       prevDone1 = 1'b0;
    always @(negedge clk) begin
        if (rst1) begin
            bcnt1 = 0;
            last1 = 8'h00;
            prevDone1 = 1'b0;
        end else begin
            checkOutput("en_vs_busy1", int'(en1), int'(busy1));
            if (busy1) begin
                checkOutput("sel1", int'(sel1), bcnt1 / 1);
                checkOutput("busy_len1", int'(bcnt1 < 8), 1);
                bcnt1++;
            end
            if (done1) begin
                checkOutput("done_pulse1", int'(prevDone1), 0);
                checkOutput("busy_cycles1", bcnt1, 8);
                if (q1.size() == 0) begin
                    failNow("sb_empty1");
                end else begin
                    last1 = q1.pop_front();
                    checkOutput("data1", int'(data1), int'(last1));
                end
                bcnt1 = 0;
            end else begin
                checkOutput("hold1", int'(data1), int'(last1));
            end
            prevDone1 = done1;
        end
    end

    // Monitor for the SETTLE=3 instance.
    int         bcnt3 = 0;
    logic [7:0] last3 = 8'h00;
    logic       prevDone3 = 1'b0;
    always @(negedge clk) begin
        if (rst3) begin
            bcnt3 = 0;
            last3 = 8'h00;
            prevDone3 = 1'b0;
        end else begin
            checkOutput("en_vs_busy3", int'(en3), int'(busy3));
            if (busy3) begin
                checkOutput("sel3", int'(sel3), bcnt3 / 3);
                checkOutput("busy_len3", int'(bcnt3 < 24), 1);
                bcnt3++;
            end
            if (done3) begin
                checkOutput("done_pulse3", int'(prevDone3), 0);
                checkOutput("busy_cycles3", bcnt3, 24);
                if (q3.size() == 0) begin
                    failNow("sb_empty3");
                end else begin
                    last3 = q3.pop_front();
                    checkOutput("data3", int'(data3), int'(last3));
                end
                bcnt3 = 0;
            end else begin
                checkOutput("hold3", int'(data3), int'(last3));
            end
            prevDone3 = done3;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int guard;
        rst1 = 1'b1;
        rst3 = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        pat1 = 8'h00;
        pat3 = 8'h00;
        #1;
        checkOutput("rst_sel", int'(sel1), 0);
        checkOutput("rst_busy", int'(busy1), 0);
        checkOutput("rst_done", int'(done1), 0);
        checkOutput("rst_data", int'(data1), 0);
        checkOutput("rst_busy3", int'(busy3), 0);
        checkOutput("rst_data3", int'(data3), 0);
        @(negedge clk);
        #2;
        rst1 = 1'b0;
        rst3 = 1'b0;

        $display("[TB] directed patterns");
        applyStimulus(1, 8'hA6);
        applyStimulus(3, 8'h5C);

        $display("[TB] random patterns");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 8'($urandom));
            applyStimulus(3, 8'($urandom));
        end

        $display("[TB] start held through a scan");
        @(negedge clk);
        pat1 = 8'h81;
        q1.push_back(8'h81);
        q1.push_back(8'h7E);
        start1 = 1'b1;
        waitDone(1, cyc);
        pat1 = 8'h7E;
        @(negedge clk);
`ifdef SCAN_CONTINUOUS_EN
        checkOutput("back_to_back", int'(busy1), 1);
`else
        checkOutput("idle_gap", int'(busy1), 0);
        checkOutput("idle_gap_done", int'(done1), 0);
        @(negedge clk);
        checkOutput("second_start", int'(busy1), 1);
`endif
        start1 = 1'b0;
        waitDone(1, cyc);

`ifdef SCAN_CONTINUOUS_EN
        $display("[TB] continuous scans");
        @(negedge clk);
        @(negedge clk);
        pat1 = 8'h3C;
        q1.push_back(8'h3C);
        q1.push_back(8'hC3);
        start1 = 1'b1;
        waitDone(1, cyc);
        pat1 = 8'hC3;
        @(negedge clk);
        waitDone(1, cyc);
        checkOutput("done_period", cyc + 1, 9);
        start1 = 1'b0;
`endif

        $display("[TB] reset mid-scan");
        applyStimulus(1, 8'h12);
        @(negedge clk);
        pat1 = 8'hFF;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        guard = 0;
        while (sel1 != 3'd4 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) failNow("reach_sel4");
        #2;
        rst1 = 1'b1;
        #1;
        checkOutput("arst_sel", int'(sel1), 0);
        checkOutput("arst_en", int'(en1), 0);
        checkOutput("arst_busy", int'(busy1), 0);
        checkOutput("arst_done", int'(done1), 0);
        checkOutput("arst_data", int'(data1), 0);
        @(negedge clk);
        #2;
        rst1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stay_idle", int'(busy1), 0);
        end
        checkOutput("post_rst_data", int'(data1), 0);
        checkOutput("sb_drained1", q1.size(), 0);
        checkOutput("sb_drained3", q3.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
